// File: rtl/i2c_seq_pkg.sv
// Shared types and ROM header field layout for the I2C init sequencer.
package i2c_seq_pkg;

   // Sequencer FSM states
   typedef enum logic [3:0] {
      S_IDLE,
      S_HDR_WAIT,
      S_HDR,
      S_REG_WAIT,
      S_REG,
      S_LOAD_WAIT,
      S_LOAD,
      S_START,
      S_ACCEPT,
      S_RUN,
      S_FAIL,
      S_NEXT,
      S_DONE,
      S_ERROR
   } seqState_t;

   // Header byte: low nibble is the data byte count, high nibble is reserved.
   localparam int N_MSB    = 3;
   localparam int RSVD_MSB = 7;
   localparam int RSVD_LSB = 4;

   // A data byte count of zero terminates the table.
   localparam logic [N_MSB:0] END_OF_TABLE = '0;

   function automatic logic [N_MSB:0] hdrCount(input logic [7:0] hdr);
      return hdr[N_MSB:0];
   endfunction

   function automatic logic [RSVD_MSB-RSVD_LSB:0] hdrReserved(input logic [7:0] hdr);
      return hdr[RSVD_MSB:RSVD_LSB];
   endfunction

endpackage

// File: rtl/i2c_init_sequencer_if.sv
// Bundle between the init sequencer and the multi-byte I2C write engine.
interface i2c_init_sequencer_if;

   logic [6:0] wr_dev_address;
   logic [7:0] wr_reg_address;
   logic [3:0] wr_byte_width;
   logic       wr_start;
   logic       wr_idle;
   logic       wr_failure;
   logic [7:0] fifo_data;
   logic       fifo_wr_en;
   logic       fifo_full;
   logic       fifo_ext_reset;

   // Sequencer side
   modport master (
      output wr_dev_address, wr_reg_address, wr_byte_width, wr_start,
             fifo_data, fifo_wr_en, fifo_ext_reset,
      input  wr_idle, wr_failure, fifo_full
   );

   // Engine side
   modport slave (
      input  wr_dev_address, wr_reg_address, wr_byte_width, wr_start,
             fifo_data, fifo_wr_en, fifo_ext_reset,
      output wr_idle, wr_failure, fifo_full
   );

endinterface

// File: rtl/seq_watchdog.sv
// Loadable saturating cycle counter with an expiry flag for transaction timeouts.
// o_expired rises in the cycle whose closing edge brings the count up to LIMIT.
module seq_watchdog #(
   parameter  int LIMIT = 100000,
   localparam int W     = $clog2(LIMIT + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_clear,
   input  logic         i_load,
   input  logic [W-1:0] i_loadValue,
   input  logic         i_enable,
   output logic         o_expired
);

   logic [W-1:0] r_count;

   // Count enabled cycles, stopping at LIMIT so the flag stays asserted
   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_loadValue;
      end else if (i_enable && (r_count != W'(LIMIT))) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_expired = (r_count >= W'(LIMIT - 1));

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks a ROM table of register writes and drives the I2C write engine for each entry.
module i2c_init_sequencer
   import i2c_seq_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR     = 7'h29,
   parameter int         ROM_AW       = 8,
   parameter int         MAX_RETRIES  = 3,
   parameter int         WAIT_TIMEOUT = 100000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_go,
   output logic [ROM_AW-1:0] o_romAddr,
   input  logic [7:0]        i_romData,
   output logic              o_busy,
   output logic              o_initDone,
   output logic              o_initError,
   output logic [7:0]        o_entryIndex,
   i2c_init_sequencer_if.master bus
);

   localparam int WD_W    = $clog2(WAIT_TIMEOUT + 1);
   localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
   localparam logic [ROM_AW-1:0] ADDR_MAX = {ROM_AW{1'b1}};

   seqState_t           r_state, w_nextState;
   logic [ROM_AW-1:0]   r_romAddr, w_romAddr;
   logic [ROM_AW-1:0]   r_entryStart, w_entryStart;
   logic [7:0]          r_regAddr, w_regAddr;
   logic [3:0]          r_byteWidth, w_byteWidth;
   logic [3:0]          r_numBytes, w_numBytes;
   logic [3:0]          r_byteCnt, w_byteCnt;
   logic [RETRY_W-1:0]  r_retryCnt, w_retryCnt;
   logic                r_failFlag, w_failFlag;
   logic [7:0]          r_entryIndex, w_entryIndex;
   logic                r_busy, w_busy;
   logic                r_initDone, w_initDone;
   logic                r_initError, w_initError;

   logic                w_wrStart;
   logic                w_fifoWrEn;
   logic                w_extReset;
   logic                w_wdLoad;
   logic                w_wdEnable;
   logic                w_wdClear;
   logic                w_wdExpired;

   seq_watchdog #(
      .LIMIT(WAIT_TIMEOUT)
   ) u_watchdog (
      .clk        (clk),
      .reset      (reset),
      .i_clear    (w_wdClear),
      .i_load     (w_wdLoad),
      .i_loadValue(WD_W'(1)),
      .i_enable   (w_wdEnable),
      .o_expired  (w_wdExpired)
   );

   // State and datapath registers; reset aborts any sequence in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_romAddr    <= '0;
         r_entryStart <= '0;
         r_regAddr    <= '0;
         r_byteWidth  <= '0;
         r_numBytes   <= '0;
         r_byteCnt    <= '0;
         r_retryCnt   <= '0;
         r_failFlag   <= 1'b0;
         r_entryIndex <= '0;
         r_busy       <= 1'b0;
         r_initDone   <= 1'b0;
         r_initError  <= 1'b0;
      end else begin
         r_state      <= w_nextState;
         r_romAddr    <= w_romAddr;
         r_entryStart <= w_entryStart;
         r_regAddr    <= w_regAddr;
         r_byteWidth  <= w_byteWidth;
         r_numBytes   <= w_numBytes;
         r_byteCnt    <= w_byteCnt;
         r_retryCnt   <= w_retryCnt;
         r_failFlag   <= w_failFlag;
         r_entryIndex <= w_entryIndex;
         r_busy       <= w_busy;
         r_initDone   <= w_initDone;
         r_initError  <= w_initError;
      end
   end

   // Next-state and strobe decode; a ROM address wrap before the terminator is a malformed table
   always_comb begin
      w_nextState  = r_state;
      w_romAddr    = r_romAddr;
      w_entryStart = r_entryStart;
      w_regAddr    = r_regAddr;
      w_byteWidth  = r_byteWidth;
      w_numBytes   = r_numBytes;
      w_byteCnt    = r_byteCnt;
      w_retryCnt   = r_retryCnt;
      w_failFlag   = r_failFlag;
      w_entryIndex = r_entryIndex;
      w_busy       = r_busy;
      w_initDone   = r_initDone;
      w_initError  = r_initError;
      w_wrStart    = 1'b0;
      w_fifoWrEn   = 1'b0;
      w_extReset   = 1'b0;
      w_wdLoad     = 1'b0;
      w_wdEnable   = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (i_go) begin
               w_initDone   = 1'b0;
               w_initError  = 1'b0;
               w_entryIndex = '0;
               w_romAddr    = '0;
               w_retryCnt   = '0;
               w_busy       = 1'b1;
               w_nextState  = S_HDR_WAIT;
            end
         end
         S_HDR_WAIT: w_nextState = S_HDR;
         S_HDR: begin
            w_entryStart = r_romAddr;
            w_numBytes   = hdrCount(i_romData);
            if (hdrReserved(i_romData) != '0) begin
               w_nextState = S_ERROR;
            end else if (hdrCount(i_romData) == END_OF_TABLE) begin
               w_nextState = S_DONE;
            end else if (r_romAddr == ADDR_MAX) begin
               w_nextState = S_ERROR;
            end else begin
               w_romAddr   = r_romAddr + 1'b1;
               w_nextState = S_REG_WAIT;
            end
         end
         S_REG_WAIT: w_nextState = S_REG;
         S_REG: begin
            w_regAddr   = i_romData;
            w_byteWidth = r_numBytes;
            w_byteCnt   = r_numBytes;
            if (r_romAddr == ADDR_MAX) begin
               w_nextState = S_ERROR;
            end else begin
               w_romAddr   = r_romAddr + 1'b1;
               w_nextState = S_LOAD_WAIT;
            end
         end
         S_LOAD_WAIT: w_nextState = S_LOAD;
         S_LOAD: begin
            if (r_romAddr == ADDR_MAX) begin
               w_nextState = S_ERROR;
            end else if (!bus.fifo_full) begin
               w_fifoWrEn  = 1'b1;
               w_romAddr   = r_romAddr + 1'b1;
               w_byteCnt   = r_byteCnt - 4'd1;
               w_nextState = (r_byteCnt == 4'd1) ? S_START : S_LOAD_WAIT;
            end
         end
         S_START: begin
            w_wrStart   = 1'b1;
            w_wdLoad    = 1'b1;
            w_failFlag  = bus.wr_failure;
            w_nextState = S_ACCEPT;
         end
         S_ACCEPT: begin
            w_wdEnable = 1'b1;
            w_failFlag = r_failFlag | bus.wr_failure;
            if (!bus.wr_idle) begin
               w_nextState = S_RUN;
            end else if (w_wdExpired) begin
               w_nextState = S_FAIL;
            end
         end
         S_RUN: begin
            w_wdEnable = 1'b1;
            w_failFlag = r_failFlag | bus.wr_failure;
            if (bus.wr_idle) begin
               w_nextState = (r_failFlag || bus.wr_failure) ? S_FAIL : S_NEXT;
            end else if (w_wdExpired) begin
               w_nextState = S_FAIL;
            end
         end
         S_FAIL: begin
            w_extReset = 1'b1;
            if (r_retryCnt < RETRY_W'(MAX_RETRIES)) begin
               w_retryCnt  = r_retryCnt + RETRY_W'(1);
               w_romAddr   = r_entryStart;
               w_nextState = S_HDR_WAIT;
            end else begin
               w_nextState = S_ERROR;
            end
         end
         S_NEXT: begin
            w_retryCnt = '0;
            if (r_entryIndex != 8'hFF) begin
               w_entryIndex = r_entryIndex + 8'd1;
            end
            w_nextState = S_HDR_WAIT;
         end
         S_DONE: begin
            w_initDone  = 1'b1;
            w_busy      = 1'b0;
            w_nextState = S_IDLE;
         end
         S_ERROR: begin
            w_initError = 1'b1;
            w_busy      = 1'b0;
            w_nextState = S_IDLE;
         end
         default: w_nextState = S_IDLE;
      endcase
   end

   assign w_wdClear = (r_state != S_START) && (r_state != S_ACCEPT) && (r_state != S_RUN);

   assign bus.wr_dev_address = DEV_ADDR;
   assign bus.wr_reg_address = r_regAddr;
   assign bus.wr_byte_width  = r_byteWidth;
   assign bus.wr_start       = w_wrStart;
   assign bus.fifo_wr_en     = w_fifoWrEn;
   assign bus.fifo_data      = w_fifoWrEn ? i_romData : 8'h00;
   assign bus.fifo_ext_reset = w_extReset;

   assign o_romAddr    = r_romAddr;
   assign o_busy       = r_busy;
   assign o_initDone   = r_initDone;
   assign o_initError  = r_initError;
   assign o_entryIndex = r_entryIndex;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Directed testbench: ROM model, behavioural write engine and per-scenario checks.
module tb_i2c_init_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       go = 1'b0;
   logic [7:0] romAddr;
   logic [7:0] romData = 8'h00;
   logic       busy, initDone, initError;
   logic [7:0] entryIndex;
   logic [7:0] rom [0:255];

   int checks = 0;
   int errors = 0;
   int cycleCnt = 0;

   // Engine model / monitor state
   int         engMode = 0;
   int         engPhase = 0;
   int         engWait = 0;
   logic       engFail = 1'b0;
   logic       failedOnce = 1'b0;
   logic [7:0] byteLog [$];
   logic [7:0] regLog [$];
   logic [3:0] widthLog [$];
   int         startCount = 0;
   int         startsEntry1 = 0;
   int         extResetCount = 0;
   int         fullWrites = 0;
   int         lastStartCycle = 0;
   int         firstFailGap = -1;

   i2c_init_sequencer_if busIf();

   i2c_init_sequencer #(
      .DEV_ADDR    (7'h29),
      .ROM_AW      (8),
      .MAX_RETRIES (3),
      .WAIT_TIMEOUT(50)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .i_go        (go),
      .o_romAddr   (romAddr),
      .i_romData   (romData),
      .o_busy      (busy),
      .o_initDone  (initDone),
      .o_initError (initError),
      .o_entryIndex(entryIndex),
      .bus         (busIf.master)
   );

   always #5 clk = ~clk;

   // Synchronous ROM: data valid the cycle after the address changes
   always @(posedge clk) romData <= rom[romAddr];

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Monitor DUT strobes and play the engine, all on the falling edge
   always @(negedge clk) begin
      if (busIf.fifo_wr_en === 1'b1) begin
         byteLog.push_back(busIf.fifo_data);
         if (busIf.fifo_full === 1'b1) fullWrites++;
      end
      if (busIf.wr_start === 1'b1) begin
         startCount++;
         regLog.push_back(busIf.wr_reg_address);
         widthLog.push_back(busIf.wr_byte_width);
         if (busIf.wr_reg_address == 8'h20) startsEntry1++;
         lastStartCycle = cycleCnt;
      end
      if (busIf.fifo_ext_reset === 1'b1) begin
         extResetCount++;
         if (firstFailGap < 0) firstFailGap = cycleCnt - lastStartCycle;
      end

      if (reset) begin
         engPhase = 0;
         busIf.wr_idle = 1'b1;
         busIf.wr_failure = 1'b0;
      end else begin
         case (engPhase)
            0: begin
               busIf.wr_idle = 1'b1;
               busIf.wr_failure = 1'b0;
               if (busIf.wr_start === 1'b1 && engMode != 3) begin
                  engFail = (engMode == 2 && busIf.wr_reg_address == 8'h20) ||
                            (engMode == 1 && busIf.wr_reg_address == 8'h10 && !failedOnce);
                  if (engMode == 1 && busIf.wr_reg_address == 8'h10) failedOnce = 1'b1;
                  engPhase = 1;
               end
            end
            1: begin
               busIf.wr_idle = 1'b0;
               engWait = 3;
               engPhase = 2;
            end
            2: begin
               engWait--;
               if (engWait == 0) begin
                  busIf.wr_idle = 1'b1;
                  busIf.wr_failure = engFail;
                  engPhase = 3;
               end
            end
            default: begin
               busIf.wr_failure = 1'b0;
               engPhase = 0;
            end
         endcase
      end
   end

   function automatic logic [63:0] packQ(input logic [7:0] q [$]);
      logic [63:0] r = '0;
      for (int i = 0; i < q.size() && i < 8; i++) r = (r << 8) | 64'(q[i]);
      return r;
   endfunction

   task automatic clearLogs(input int mode);
      byteLog.delete();
      regLog.delete();
      widthLog.delete();
      startCount = 0;
      startsEntry1 = 0;
      extResetCount = 0;
      fullWrites = 0;
      firstFailGap = -1;
      failedOnce = 1'b0;
      engMode = mode;
   endtask

   task automatic loadTable1();
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
      rom[0] = 8'h02; rom[1] = 8'h10; rom[2] = 8'hAA; rom[3] = 8'hBB;
      rom[4] = 8'h01; rom[5] = 8'h20; rom[6] = 8'hCC; rom[7] = 8'h00;
   endtask

   task automatic pulseGo();
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic waitIdle(input string name, input int maxCycles);
      int n = 0;
      while (busy !== 1'b0 && n < maxCycles) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
      end
   endtask

   task automatic applyStimulus(input string name, input int maxCycles);
      pulseGo();
      waitIdle(name, maxCycles);
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      checks++;
      if ({busy, initDone, initError} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_flags: busy/done/err=%b, required 000", {busy, initDone, initError});
      end
      checks++;
      if (romAddr !== 8'h00 || entryIndex !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_addr: rom_addr=%h entry_index=%h, required 00 00", romAddr, entryIndex);
      end
      checks++;
      if ({busIf.wr_start, busIf.fifo_wr_en, busIf.fifo_ext_reset} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_strobes: start/wr_en/ext_reset=%b, required 000",
                  {busIf.wr_start, busIf.fifo_wr_en, busIf.fifo_ext_reset});
      end
      checks++;
      if ({busIf.wr_reg_address, busIf.wr_byte_width, busIf.fifo_data} !== 20'h0) begin
         errors++;
         $display("[TB] FAIL reset_bus: reg=%h width=%h data=%h, required all 0",
                  busIf.wr_reg_address, busIf.wr_byte_width, busIf.fifo_data);
      end
      checks++;
      if (busIf.wr_dev_address !== 7'h29) begin
         errors++;
         $display("[TB] FAIL reset_dev: got %h, required 29", busIf.wr_dev_address);
      end
   endtask

   task automatic test_basic();
      loadTable1();
      clearLogs(0);
      applyStimulus("basic", 500);
      checks++;
      if (byteLog.size() != 3 || packQ(byteLog) !== 64'hAABBCC) begin
         errors++;
         $display("[TB] FAIL basic_bytes: got %0d bytes %h, required 3 bytes aabbcc", byteLog.size(), packQ(byteLog));
      end
      checks++;
      if (regLog.size() != 2 || packQ(regLog) !== 64'h1020) begin
         errors++;
         $display("[TB] FAIL basic_regs: got %h, required 1020", packQ(regLog));
      end
      checks++;
      if (widthLog.size() != 2 || widthLog[0] !== 4'd2 || widthLog[1] !== 4'd1) begin
         errors++;
         $display("[TB] FAIL basic_width: got %0d entries, required widths 2 then 1", widthLog.size());
      end
      checks++;
      if (startCount != 2) begin
         errors++;
         $display("[TB] FAIL basic_starts: got %0d, required 2", startCount);
      end
      checks++;
      if (initDone !== 1'b1 || initError !== 1'b0 || entryIndex !== 8'd2) begin
         errors++;
         $display("[TB] FAIL basic_status: done=%b err=%b idx=%0d, required 1 0 2", initDone, initError, entryIndex);
      end
   endtask

   task automatic test_retry_once();
      loadTable1();
      clearLogs(1);
      applyStimulus("retry", 800);
      checks++;
      if (extResetCount != 1) begin
         errors++;
         $display("[TB] FAIL retry_ext_reset: got %0d pulses, required 1", extResetCount);
      end
      checks++;
      if (byteLog.size() != 5 || packQ(byteLog) !== 64'hAABBAABBCC) begin
         errors++;
         $display("[TB] FAIL retry_bytes: got %h, required aabbaabbcc", packQ(byteLog));
      end
      checks++;
      if (startCount != 3) begin
         errors++;
         $display("[TB] FAIL retry_starts: got %0d, required 3", startCount);
      end
      checks++;
      if (initDone !== 1'b1 || initError !== 1'b0 || entryIndex !== 8'd2) begin
         errors++;
         $display("[TB] FAIL retry_status: done=%b err=%b idx=%0d, required 1 0 2", initDone, initError, entryIndex);
      end
   endtask

   task automatic test_retry_exhaust();
      loadTable1();
      clearLogs(2);
      applyStimulus("exhaust", 1500);
      checks++;
      if (startsEntry1 != 4) begin
         errors++;
         $display("[TB] FAIL exhaust_starts: got %0d starts for entry 1, required 4", startsEntry1);
      end
      checks++;
      if (extResetCount != 4) begin
         errors++;
         $display("[TB] FAIL exhaust_ext_reset: got %0d, required 4", extResetCount);
      end
      checks++;
      if (initError !== 1'b1 || initDone !== 1'b0 || entryIndex !== 8'd1) begin
         errors++;
         $display("[TB] FAIL exhaust_status: done=%b err=%b idx=%0d, required 0 1 1", initDone, initError, entryIndex);
      end
   endtask

   task automatic test_fifo_full();
      int n = 0;
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
      rom[0] = 8'h03; rom[1] = 8'h30; rom[2] = 8'h11; rom[3] = 8'h22; rom[4] = 8'h33; rom[5] = 8'h00;
      clearLogs(0);
      pulseGo();
      while (busIf.fifo_wr_en !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      #1 busIf.fifo_full = 1'b1;
      repeat (5) @(negedge clk);
      #1 busIf.fifo_full = 1'b0;
      waitIdle("full", 500);
      checks++;
      if (fullWrites != 0) begin
         errors++;
         $display("[TB] FAIL full_write_while_full: got %0d writes, required 0", fullWrites);
      end
      checks++;
      if (byteLog.size() != 3 || packQ(byteLog) !== 64'h112233) begin
         errors++;
         $display("[TB] FAIL full_bytes: got %0d bytes %h, required 112233", byteLog.size(), packQ(byteLog));
      end
      checks++;
      if (regLog.size() != 1 || regLog[0] !== 8'h30 || widthLog[0] !== 4'd3) begin
         errors++;
         $display("[TB] FAIL full_entry: got %0d starts, required one start reg 30 width 3", regLog.size());
      end
      checks++;
      if (initDone !== 1'b1 || entryIndex !== 8'd1) begin
         errors++;
         $display("[TB] FAIL full_status: done=%b idx=%0d, required 1 1", initDone, entryIndex);
      end
   endtask

   task automatic test_timeout();
      loadTable1();
      clearLogs(3);
      applyStimulus("timeout", 2000);
      checks++;
      if (firstFailGap != 50) begin
         errors++;
         $display("[TB] FAIL timeout_gap: FAIL entered %0d cycles after start, required 50", firstFailGap);
      end
      checks++;
      if (startCount != 4 || extResetCount != 4) begin
         errors++;
         $display("[TB] FAIL timeout_attempts: starts=%0d ext_resets=%0d, required 4 4", startCount, extResetCount);
      end
      checks++;
      if (initError !== 1'b1 || initDone !== 1'b0 || entryIndex !== 8'd0) begin
         errors++;
         $display("[TB] FAIL timeout_status: done=%b err=%b idx=%0d, required 0 1 0", initDone, initError, entryIndex);
      end
   endtask

   task automatic test_reset_mid_run();
      int n = 0;
      loadTable1();
      clearLogs(0);
      pulseGo();
      while (busIf.wr_idle !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busIf.wr_idle !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrun_reach: engine idle=%b, required 0", busIf.wr_idle);
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, initDone, initError, romAddr, entryIndex} !== 19'h0) begin
         errors++;
         $display("[TB] FAIL midrun_status: busy=%b done=%b err=%b addr=%h idx=%h, required all 0",
                  busy, initDone, initError, romAddr, entryIndex);
      end
      checks++;
      if ({busIf.wr_start, busIf.fifo_wr_en, busIf.fifo_ext_reset, busIf.wr_reg_address, busIf.wr_byte_width} !== 15'h0) begin
         errors++;
         $display("[TB] FAIL midrun_bus: start=%b wr_en=%b ext=%b reg=%h width=%h, required all 0",
                  busIf.wr_start, busIf.fifo_wr_en, busIf.fifo_ext_reset, busIf.wr_reg_address, busIf.wr_byte_width);
      end
      reset = 1'b0;
      rom[0] = 8'h81;
      clearLogs(0);
      applyStimulus("badhdr", 100);
      checks++;
      if (initError !== 1'b1 || initDone !== 1'b0 || entryIndex !== 8'd0) begin
         errors++;
         $display("[TB] FAIL badhdr_status: done=%b err=%b idx=%0d, required 0 1 0", initDone, initError, entryIndex);
      end
      checks++;
      if (startCount != 0 || byteLog.size() != 0) begin
         errors++;
         $display("[TB] FAIL badhdr_activity: starts=%0d bytes=%0d, required 0 0", startCount, byteLog.size());
      end
   endtask

   // Test sequence
   initial begin
      busIf.fifo_full = 1'b0;
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
      repeat (4) @(negedge clk);
      test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      test_basic();
      test_retry_once();
      test_retry_exhaust();
      test_fifo_full();
      test_timeout();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
